// File: rtl/pfsoc_fabric_reset_sequencer.sv
// Fabric reset sequencer: waits for device init and bank VDDI, qualifies the
// fabric PLL lock with a consecutive-cycle filter, holds reset for a fixed
// number of cycles and then releases FABRIC_RESET_N. Lock loss, init loss or a
// software request in RUN re-enters the reset sequence. Reset assertion is
// asynchronous; every release path is synchronous to CLK.
module pfsoc_fabric_reset_sequencer #(
  parameter int SYNC_STAGES       = 2,
  parameter int PLL_LOCK_FILTER   = 16,
  parameter int RESET_HOLD_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       EXT_RST_N,
  input  logic       INIT_DONE,
  input  logic       BANK_VDDI_STATUS,
  input  logic       PLL_LOCK,
  input  logic       SS_BUSY,
  input  logic       SOFT_RST_REQ,
  output logic       PLL_POWERDOWN_B,
  output logic       FABRIC_RESET_N,
  output logic       READY,
  output logic [2:0] STATE,
  output logic [7:0] LOSS_COUNT
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  // One counter serves both the lock filter (WAIT_LOCK) and the hold timer
  // (HOLD); it is sized for whichever terminal count needs more bits.
  localparam int LOCK_W = (PLL_LOCK_FILTER > 1) ? $clog2(PLL_LOCK_FILTER) : 1;
  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int CNT_W  = (LOCK_W > HOLD_W) ? LOCK_W : HOLD_W;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(PLL_LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

  localparam int N_SYNC = 4;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic [N_SYNC-1:0] async_in;
  logic [N_SYNC-1:0] sync_out;

  assign async_in = {SS_BUSY, PLL_LOCK, BANK_VDDI_STATUS, INIT_DONE};

  genvar gi;
  generate
    for (gi = 0; gi < N_SYNC; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      // Shift the raw status bit through SYNC_STAGES flops, cleared on reset.
      always_ff @(posedge CLK or negedge EXT_RST_N) begin
        if (!EXT_RST_N) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
        end
      end

      assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic init_s;
  logic vddi_s;
  logic lock_s;
  logic busy_s;
  logic ok_s;

  assign init_s = sync_out[0];
  assign vddi_s = sync_out[1];
  assign lock_s = sync_out[2];
  assign busy_s = sync_out[3];
  assign ok_s   = init_s & vddi_s;

  // ---------------------------------------------------------------------
  // State, counter and loss counter
  // ---------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       loss_reg;
  logic [7:0]       loss_next;
  logic             loss_event;

  logic             frn_reg;
  logic             ready_reg;
  logic             pdb_reg;

  // Register the next state together with the outputs decoded from it, so
  // every output changes on the same edge as STATE.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      state_reg <= ST_RESET;
      cnt_reg   <= '0;
      loss_reg  <= '0;
      frn_reg   <= 1'b0;
      ready_reg <= 1'b0;
      pdb_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      loss_reg  <= loss_next;
      frn_reg   <= (state_next == ST_RUN);
      ready_reg <= (state_next == ST_RUN);
      pdb_reg   <= (state_next != ST_RESET) && (state_next != ST_WAIT_INIT);
    end
  end

  // Next-state and counter logic. The counter is cleared on every state
  // change so each phase starts counting from zero.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_event = 1'b0;

    case (state_reg)
      ST_RESET: begin
        state_next = ST_WAIT_INIT;
        cnt_next   = '0;
      end

      ST_WAIT_INIT: begin
        cnt_next = '0;
        if (ok_s) begin
          state_next = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        if (!ok_s) begin
          state_next = ST_WAIT_INIT;
          cnt_next   = '0;
        end else if (!lock_s) begin
          // Any lock dropout restarts the full qualification window.
          cnt_next = '0;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (!ok_s) begin
          state_next = ST_WAIT_INIT;
          cnt_next   = '0;
        end else if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          // Hold time is complete; system services may still block release.
          if (!busy_s) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_RUN: begin
        cnt_next = '0;
        if (!ok_s) begin
          state_next = ST_WAIT_INIT;
          loss_event = 1'b1;
        end else if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          loss_event = 1'b1;
        end else if (SOFT_RST_REQ) begin
          state_next = ST_HOLD;
        end
      end

      default: begin
        // Encodings 5..7 are unreachable in normal operation; recover.
        state_next = ST_RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // Saturating count of RUN exits caused by init or lock loss.
  always_comb begin
    loss_next = loss_reg;
    if (loss_event && (loss_reg != 8'hFF)) begin
      loss_next = loss_reg + 8'd1;
    end
  end

  assign STATE           = state_reg;
  assign FABRIC_RESET_N  = frn_reg;
  assign READY           = ready_reg;
  assign PLL_POWERDOWN_B = pdb_reg;
  assign LOSS_COUNT      = loss_reg;

endmodule

// File: tb/tb_pfsoc_fabric_reset_sequencer.sv
// Directed bench for the fabric reset sequencer with default parameters.
// Expected edge counts are worked out by hand from the sequencing rules.
module tb_pfsoc_fabric_reset_sequencer;

  logic       CLK = 1'b0;
  logic       EXT_RST_N;
  logic       INIT_DONE;
  logic       BANK_VDDI_STATUS;
  logic       PLL_LOCK;
  logic       SS_BUSY;
  logic       SOFT_RST_REQ;
  logic       PLL_POWERDOWN_B;
  logic       FABRIC_RESET_N;
  logic       READY;
  logic [2:0] STATE;
  logic [7:0] LOSS_COUNT;

  int n_checks = 0;
  int n_fails  = 0;

  pfsoc_fabric_reset_sequencer #(
    .SYNC_STAGES      (2),
    .PLL_LOCK_FILTER  (16),
    .RESET_HOLD_CYCLES(32)
  ) dut (
    .CLK             (CLK),
    .EXT_RST_N       (EXT_RST_N),
    .INIT_DONE       (INIT_DONE),
    .BANK_VDDI_STATUS(BANK_VDDI_STATUS),
    .PLL_LOCK        (PLL_LOCK),
    .SS_BUSY         (SS_BUSY),
    .SOFT_RST_REQ    (SOFT_RST_REQ),
    .PLL_POWERDOWN_B (PLL_POWERDOWN_B),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .READY           (READY),
    .STATE           (STATE),
    .LOSS_COUNT      (LOSS_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges, leaving time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Count edges until FABRIC_RESET_N reaches level, bounded by limit.
  task automatic wait_frn(input logic level, input int limit, output int edges);
    edges = 0;
    do begin
      @(posedge CLK);
      #1;
      edges++;
    end while ((FABRIC_RESET_N !== level) && (edges < limit));
  endtask

  initial begin
    int e;
    int exp_state;

    EXT_RST_N        = 1'b0;
    INIT_DONE        = 1'b1;
    BANK_VDDI_STATUS = 1'b1;
    PLL_LOCK         = 1'b1;
    SS_BUSY          = 1'b0;
    SOFT_RST_REQ     = 1'b0;

    // Reset state
    tick(3);
    check_val("rst_state", 32'(STATE), 0);
    check_val("rst_frn", 32'(FABRIC_RESET_N), 0);
    check_val("rst_pdb", 32'(PLL_POWERDOWN_B), 0);
    check_val("rst_ready", 32'(READY), 0);
    check_val("rst_loss", 32'(LOSS_COUNT), 0);

    // Power-up: PDB at edge 3, release at edge 51
    EXT_RST_N = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      tick(1);
      exp_state = (k < 3) ? 1 : (k < 19) ? 2 : (k < 51) ? 3 : 4;
      check_val($sformatf("pwrup_pdb_e%0d", k), 32'(PLL_POWERDOWN_B), (k >= 3) ? 1 : 0);
      check_val($sformatf("pwrup_frn_e%0d", k), 32'(FABRIC_RESET_N), (k >= 51) ? 1 : 0);
      check_val($sformatf("pwrup_state_e%0d", k), 32'(STATE), 32'(exp_state));
    end
    check_val("pwrup_ready", 32'(READY), 1);
    check_val("pwrup_loss", 32'(LOSS_COUNT), 0);
    $display("powerup: release observed, STATE=%0d", STATE);

    // Lock loss in RUN, then relock (48 edges after lock_s rises = 50 edges)
    PLL_LOCK = 1'b0;
    wait_frn(1'b0, 10, e);
    check_val("lockloss_lat", 32'(e), 3);
    check_val("lockloss_state", 32'(STATE), 2);
    check_val("lockloss_loss", 32'(LOSS_COUNT), 1);
    check_val("lockloss_ready", 32'(READY), 0);
    check_val("lockloss_pdb", 32'(PLL_POWERDOWN_B), 1);
    PLL_LOCK = 1'b1;
    wait_frn(1'b1, 100, e);
    check_val("relock_lat", 32'(e), 50);
    $display("lock loss/relock: fall 3, rise %0d edges", e);

    // Soft reset in RUN: low for exactly 32 edges, loss count unchanged
    SOFT_RST_REQ = 1'b1;
    tick(1);
    SOFT_RST_REQ = 1'b0;
    check_val("soft_frn_low", 32'(FABRIC_RESET_N), 0);
    check_val("soft_state", 32'(STATE), 3);
    wait_frn(1'b1, 100, e);
    check_val("soft_len", 32'(e), 32);
    check_val("soft_loss", 32'(LOSS_COUNT), 1);
    $display("soft reset: release after %0d edges", e);

    // Soft request in WAIT_LOCK is ignored
    PLL_LOCK = 1'b0;
    wait_frn(1'b0, 10, e);
    check_val("wl_lat", 32'(e), 3);
    check_val("wl_loss", 32'(LOSS_COUNT), 2);
    PLL_LOCK = 1'b1;
    tick(5);
    SOFT_RST_REQ = 1'b1;
    tick(1);
    SOFT_RST_REQ = 1'b0;
    check_val("wl_soft_state", 32'(STATE), 2);
    wait_frn(1'b1, 100, e);
    check_val("wl_soft_release", 32'(e), 44);
    $display("soft in WAIT_LOCK: release after %0d more edges", e);

    // Lock chatter: one-cycle lock_s low at counter 10 restarts filter
    PLL_LOCK = 1'b0;
    wait_frn(1'b0, 10, e);
    check_val("chat_fall", 32'(e), 3);
    PLL_LOCK = 1'b1;
    tick(10);
    PLL_LOCK = 1'b0;
    tick(1);
    PLL_LOCK = 1'b1;
    tick(3);
    check_val("chat_state", 32'(STATE), 2);
    check_val("chat_frn", 32'(FABRIC_RESET_N), 0);
    wait_frn(1'b1, 100, e);
    check_val("chat_release", 32'(e), 47);
    $display("lock chatter: release 61 edges after relock (measured tail %0d)", e);

    // SS_BUSY blocks release; RUN 3 edges after drop
    PLL_LOCK = 1'b0;
    SS_BUSY  = 1'b1;
    wait_frn(1'b0, 10, e);
    check_val("busy_fall", 32'(e), 3);
    check_val("busy_loss", 32'(LOSS_COUNT), 4);
    PLL_LOCK = 1'b1;
    tick(49);
    check_val("busy_hold_done", 32'(STATE), 3);
    tick(20);
    check_val("busy_hold_state", 32'(STATE), 3);
    check_val("busy_hold_frn", 32'(FABRIC_RESET_N), 0);
    SS_BUSY = 1'b0;
    wait_frn(1'b1, 10, e);
    check_val("busy_release", 32'(e), 3);
    $display("ss_busy: release %0d edges after drop", e);

    // Simultaneous init+lock loss: one transition, one increment
    INIT_DONE = 1'b0;
    PLL_LOCK  = 1'b0;
    wait_frn(1'b0, 10, e);
    check_val("dual_lat", 32'(e), 3);
    check_val("dual_state", 32'(STATE), 1);
    check_val("dual_loss", 32'(LOSS_COUNT), 5);
    check_val("dual_pdb", 32'(PLL_POWERDOWN_B), 0);
    tick(2);
    check_val("dual_loss_hold", 32'(LOSS_COUNT), 5);
    INIT_DONE = 1'b1;
    PLL_LOCK  = 1'b1;
    wait_frn(1'b1, 100, e);
    check_val("dual_release", 32'(e), 51);
    $display("dual loss: release %0d edges after restore", e);

    // EXT_RST_N mid-HOLD acts without a clock edge
    PLL_LOCK = 1'b0;
    wait_frn(1'b0, 10, e);
    check_val("hold_loss", 32'(LOSS_COUNT), 6);
    PLL_LOCK = 1'b1;
    tick(25);
    check_val("prehold_state", 32'(STATE), 3);
    #3;
    EXT_RST_N = 1'b0;
    #1;
    check_val("arst_hold_state", 32'(STATE), 0);
    check_val("arst_hold_pdb", 32'(PLL_POWERDOWN_B), 0);
    check_val("arst_hold_frn", 32'(FABRIC_RESET_N), 0);
    check_val("arst_hold_loss", 32'(LOSS_COUNT), 0);
    tick(2);
    EXT_RST_N = 1'b1;
    wait_frn(1'b1, 100, e);
    check_val("arst_hold_rel", 32'(e), 51);

    // EXT_RST_N mid-RUN
    #4;
    EXT_RST_N = 1'b0;
    #1;
    check_val("arst_run_frn", 32'(FABRIC_RESET_N), 0);
    check_val("arst_run_ready", 32'(READY), 0);
    check_val("arst_run_state", 32'(STATE), 0);
    check_val("arst_run_pdb", 32'(PLL_POWERDOWN_B), 0);
    tick(2);
    EXT_RST_N = 1'b1;
    wait_frn(1'b1, 100, e);
    check_val("arst_run_rel", 32'(e), 51);
    $display("async reset: HOLD and RUN cleared immediately");

    // 300 lock-loss events: LOSS_COUNT saturates at 255
    for (int i = 1; i <= 300; i++) begin
      PLL_LOCK = 1'b0;
      wait_frn(1'b0, 10, e);
      if (e != 3) check_val($sformatf("sat_fall_%0d", i), 32'(e), 3);
      PLL_LOCK = 1'b1;
      wait_frn(1'b1, 100, e);
      if (e != 50) check_val($sformatf("sat_rise_%0d", i), 32'(e), 50);
      if (i == 1 || i == 100 || i == 254 || i == 255 || i == 256 || i == 300) begin
        check_val($sformatf("sat_loss_%0d", i), 32'(LOSS_COUNT), (i > 255) ? 255 : 32'(i));
        $display("loss events %0d: LOSS_COUNT=%0d", i, LOSS_COUNT);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
